// File: rtl/sumador_serie_ctrl.sv
// Bit-serial adder controller: shifts two latched operands LSB-first through a full adder,
// keeping the running carry in an external 1-bit carry memory (salida/wm/ce out, carry_mem in).
module sumador_serie_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         carry_mem,
  output logic         salida,
  output logic         wm,
  output logic         ce,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         busy,
  output logic         done
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, INIT, SHIFT, FIN} state_t;

  state_t         state;
  state_t         nextState;
  logic [N-1:0]   aShift;
  logic [N-1:0]   bShift;
  logic           cinReg;
  logic [CW-1:0]  count;
  logic           bitSum;
  logic           bitCarry;
  logic           lastBit;

  // Full adder on the current LSBs; the carry-in comes back from the external carry memory
  always_comb begin
    bitSum   = aShift[0] ^ bShift[0] ^ carry_mem;
    bitCarry = (aShift[0] & bShift[0]) | (aShift[0] & carry_mem) | (bShift[0] & carry_mem);
    lastBit  = (count == CW'(N - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (start) nextState = INIT;
      INIT:    nextState = SHIFT;
      SHIFT:   if (lastBit) nextState = FIN;
      FIN:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // In INIT the carry memory is preloaded with the captured carry-in
  always_comb begin
    salida = 1'b0;
    wm     = 1'b0;
    ce     = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state)
      INIT: begin
        salida = cinReg;
        wm     = 1'b1;
        ce     = 1'b1;
        busy   = 1'b1;
      end
      SHIFT: begin
        salida = bitCarry;
        wm     = 1'b1;
        ce     = 1'b1;
        busy   = 1'b1;
      end
      FIN: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Sum enters at the MSB so that after N shifts bit i has landed in sum[i]
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      aShift <= '0;
      bShift <= '0;
      cinReg <= 1'b0;
      count  <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            aShift <= a;
            bShift <= b;
            cinReg <= cin;
          end
        end
        INIT: begin
          count <= '0;
        end
        SHIFT: begin
          aShift <= aShift >> 1;
          bShift <= bShift >> 1;
          sum    <= N'({bitSum, sum} >> 1);
          count  <= count + CW'(1);
          if (lastBit) cout <= bitCarry;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_serie_ctrl.sv
// Bench for sumador_serie_ctrl wired to a behavioural 1-bit carry memory, checked every cycle
// against an arithmetic reference model plus directed literal expectations.
module tb_sumador_serie_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         cin = 1'b0;
  logic         carryMem;
  logic         salida, wm, ce, cout, busy, done;
  logic [N-1:0] sum;

  int checks = 0;
  int errors = 0;

  sumador_serie_ctrl #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .cin(cin),
    .carry_mem(carryMem), .salida(salida), .wm(wm), .ce(ce),
    .sum(sum), .cout(cout), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Carry memory: mux selecting new/held value feeding a 1-bit register, sharing reset
  always @(posedge clk or negedge reset) begin
    if (!reset) carryMem <= 1'b0;
    else if (ce) carryMem <= wm ? salida : carryMem;
  end

  // Reference model: k counts cycles since the accepting edge (1 = INIT, N+2 = result cycle)
  bit           mActive = 0;
  int           k = 0;
  logic [N-1:0] mA = '0, mB = '0;
  logic         mC = 1'b0;
  logic [N-1:0] expSum = '0;
  logic         expCout = 1'b0;

  function automatic logic carryOutOfBit(int i);
    logic [N:0] m;
    logic [N:0] t;
    m = ((N+1)'(1) << (i + 1)) - (N+1)'(1);
    t = ({1'b0, mA} & m) + ({1'b0, mB} & m) + (N+1)'(mC);
    return t[i+1];
  endfunction

  always @(posedge clk or negedge reset) begin
    logic [N:0] tot;
    if (!reset) begin
      mActive = 0;
      k = 0;
      expSum = '0;
      expCout = 1'b0;
    end else if (!mActive) begin
      if (start) begin
        mActive = 1;
        k = 1;
        mA = a;
        mB = b;
        mC = cin;
      end
    end else begin
      if (k == N + 1) begin
        tot = (N+1)'(mA) + (N+1)'(mB) + (N+1)'(mC);
        expSum = tot[N-1:0];
        expCout = tot[N];
      end
      if (k == N + 2) mActive = 0;
      else k++;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic eBusy, eDone, eSal;
    if (reset) begin
      eBusy = mActive && (k <= N + 1);
      eDone = mActive && (k == N + 2);
      eSal  = 1'b0;
      if (mActive && k == 1) eSal = mC;
      else if (mActive && k >= 2 && k <= N + 1) eSal = carryOutOfBit(k - 2);
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("done", 32'(done), 32'(eDone));
      checkOutput("wm", 32'(wm), 32'(eBusy));
      checkOutput("ce", 32'(ce), 32'(eBusy));
      checkOutput("salida", 32'(salida), 32'(eSal));
      if (!eBusy) begin
        checkOutput("sum", 32'(sum), 32'(expSum));
        checkOutput("cout", 32'(cout), 32'(expCout));
      end
    end
  end

  // Called #1 after the accepting edge; returns once done is seen or the budget runs out
  task automatic waitDone(output int lat, output int busyCnt, output int salOnes, output logic initSal);
    lat = 1;
    busyCnt = 0;
    salOnes = 0;
    initSal = salida & wm & ce;
    while (!done && lat < 3 * N + 10) begin
      if (busy) busyCnt++;
      if (lat >= 2 && salida) salOnes++;
      @(posedge clk); #1;
      lat++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL done timeout: got no done after %0d cycles, expected at %0d", lat, N + 2);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] av, input logic [N-1:0] bv, input logic cv,
                               output int lat, output int busyCnt, output int salOnes,
                               output logic initSal);
    @(posedge clk); #1;
    a = av;
    b = bv;
    cin = cv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone(lat, busyCnt, salOnes, initSal);
  endtask

  initial begin
    int lat, busyCnt, salOnes;
    logic initSal;
    logic [N-1:0] ra, rb;
    logic rc;
    logic [N:0] want;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset sum", 32'(sum), 32'h0);
    checkOutput("reset cout", 32'(cout), 32'h0);
    checkOutput("reset busy", 32'(busy), 32'h0);
    checkOutput("reset done", 32'(done), 32'h0);
    checkOutput("reset salida", 32'(salida), 32'h0);
    checkOutput("reset wm", 32'(wm), 32'h0);
    checkOutput("reset ce", 32'(ce), 32'h0);
    reset = 1'b1;

    applyStimulus(8'h5A, 8'h33, 1'b0, lat, busyCnt, salOnes, initSal);
    checkOutput("t1 latency", 32'(lat), 32'(N + 2));
    checkOutput("t1 sum", 32'(sum), 32'h8D);
    checkOutput("t1 cout", 32'(cout), 32'h0);
    checkOutput("t1 busy cycles", 32'(busyCnt), 32'd9);

    applyStimulus(8'hFF, 8'h01, 1'b0, lat, busyCnt, salOnes, initSal);
    checkOutput("t2 sum", 32'(sum), 32'h00);
    checkOutput("t2 cout", 32'(cout), 32'h1);
    checkOutput("t2 salida ones", 32'(salOnes), 32'd8);

    applyStimulus(8'hFF, 8'h00, 1'b1, lat, busyCnt, salOnes, initSal);
    checkOutput("t3 sum", 32'(sum), 32'h00);
    checkOutput("t3 cout", 32'(cout), 32'h1);
    checkOutput("t3 init salida/wm/ce", 32'(initSal), 32'h1);

    // start held high with operands disturbed mid-operation
    @(posedge clk); #1;
    a = 8'h12;
    b = 8'h34;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    a = 8'($urandom);
    b = 8'($urandom);
    cin = 1'($urandom);
    waitDone(lat, busyCnt, salOnes, initSal);
    checkOutput("t4 sum", 32'(sum), 32'h46);
    checkOutput("t4 cout", 32'(cout), 32'h0);
    @(posedge clk); #1;
    checkOutput("t4 idle gap busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    checkOutput("t4 second accept busy", 32'(busy), 32'h1);
    start = 1'b0;
    waitDone(lat, busyCnt, salOnes, initSal);
    want = (N+1)'(a) + (N+1)'(b) + (N+1)'(cin);
    checkOutput("t4 second result", 32'({cout, sum}), 32'(want));

    // asynchronous reset during SHIFT bit 3
    @(posedge clk); #1;
    a = 8'hC3;
    b = 8'h5F;
    cin = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("t5 abort busy", 32'(busy), 32'h0);
    checkOutput("t5 abort done", 32'(done), 32'h0);
    checkOutput("t5 abort sum", 32'(sum), 32'h0);
    checkOutput("t5 abort cout", 32'(cout), 32'h0);
    checkOutput("t5 abort salida/wm/ce", 32'({salida, wm, ce}), 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
      checkOutput("t5 no done in reset", 32'(done), 32'h0);
    end
    reset = 1'b1;
    applyStimulus(8'h80, 8'h80, 1'b0, lat, busyCnt, salOnes, initSal);
    checkOutput("t5 sum", 32'(sum), 32'h00);
    checkOutput("t5 cout", 32'(cout), 32'h1);

    for (int i = 0; i < 500; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      applyStimulus(ra, rb, rc, lat, busyCnt, salOnes, initSal);
      want = (N+1)'(ra) + (N+1)'(rb) + (N+1)'(rc);
      checkOutput("random result", 32'({cout, sum}), 32'(want));
      checkOutput("random latency", 32'(lat), 32'(N + 2));
    end

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
